// File: rtl/common_bus_pkg.sv
// Shared types for the common-bus core.
// Opcodes, ALU ops, controller states and bus sources.
package common_bus_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_XOR  = 4'd2,
    OP_NAND = 4'd3,
    OP_SLL  = 4'd4,
    OP_SRL  = 4'd5,
    OP_SRA  = 4'd6,
    OP_NOR  = 4'd7,
    OP_ADDI = 4'd8,
    OP_BEQ  = 4'd9,
    OP_HALT = 4'd15
  } opcode_t;

  typedef enum logic [2:0] {
    A_PLUS_B,
    A_MINUS_B,
    A_XOR_B,
    A_NAND_B,
    A_SLL_B,
    A_SRL_B,
    A_SRA_B,
    A_NOR_B
  } alu_op_t;

  typedef enum logic [2:0] {
    FETCH,
    SRC1,
    SRC2,
    EXEC,
    PCUPD,
    HALTED
  } core_state_t;

  typedef enum logic [2:0] {
    BUS_NONE,
    BUS_RS1,
    BUS_RS2,
    BUS_IMM,
    BUS_ALU,
    BUS_PC
  } bus_sel_t;

endpackage

// File: rtl/common_bus_alu.sv
// Combinational ALU for the common-bus core.
// Shifts use the low log2(DATA_W) bits of b.
module common_bus_alu
  import common_bus_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] sh;
  assign sh = b[SH_W-1:0];

  always_comb begin
    result = '0;
    case (op)
      A_PLUS_B:  result = a + b;
      A_MINUS_B: result = a - b;
      A_XOR_B:   result = a ^ b;
      A_NAND_B:  result = ~(a & b);
      A_SLL_B:   result = a << sh;
      A_SRL_B:   result = a >> sh;
      A_SRA_B:   result = DATA_W'($signed(a) >>> sh);
      A_NOR_B:   result = ~(a | b);
      default:   result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/common_bus_core.sv
// Multi-cycle CPU core built around one shared data bus.
// FETCH -> SRC1 -> SRC2 -> EXEC -> PCUPD, with a sticky HALTED state.
module common_bus_core
  import common_bus_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int PC_W     = 8,
  parameter int PC_STEP  = 4,
  localparam int REG_AW  = $clog2(NUM_REGS),
  localparam int INSTR_W = 4 + 3 * REG_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  input  logic [REG_AW-1:0]  dbg_sel,
  input  logic               dbg_pc_sel,
  output logic [DATA_W-1:0]  dbg_out
);

  localparam int BUS_W = (DATA_W > PC_W) ? DATA_W : PC_W;

  core_state_t state, next_state;
  bus_sel_t    bus_sel;
  logic [BUS_W-1:0] bus;

  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  a_q, b_q;
  logic [PC_W-1:0]    pc_q;
  logic               take_branch;
  logic [DATA_W-1:0]  rf [NUM_REGS];

  logic ir_en, a_en, b_en, rf_we, br_en, pc_en;

  logic [OP_W-1:0]   op;
  logic [REG_AW-1:0] rs1, rs2, rd;
  assign op  = ir[OP_W-1:0];
  assign rs2 = ir[OP_W+:REG_AW];
  assign rs1 = ir[OP_W+REG_AW+:REG_AW];
  assign rd  = ir[OP_W+2*REG_AW+:REG_AW];

  logic is_alu, is_addi, is_beq, is_halt;
  assign is_alu  = ~op[3];
  assign is_addi = (op == OP_ADDI);
  assign is_beq  = (op == OP_BEQ);
  assign is_halt = (op == OP_HALT);

  alu_op_t           alu_op;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;

  always_comb begin
    alu_op = A_PLUS_B;
    if (is_alu)
      alu_op = alu_op_t'(op[2:0]);
    else if (is_beq)
      alu_op = A_MINUS_B;
  end

  common_bus_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (alu_op),
    .a      (a_q),
    .b      (b_q),
    .result (alu_res),
    .zero   (alu_zero)
  );

  // rd doubles as a signed instruction-count offset for BEQ
  logic [PC_W-1:0] br_off, pc_next;
  assign br_off = {{(PC_W-REG_AW){rd[REG_AW-1]}}, rd}
                * PC_W'(PC_STEP);
  assign pc_next = take_branch ? pc_q + br_off
                               : pc_q + PC_W'(PC_STEP);

  always_comb begin
    next_state  = state;
    bus_sel     = BUS_NONE;
    instr_ready = 1'b0;
    ir_en       = 1'b0;
    a_en        = 1'b0;
    b_en        = 1'b0;
    rf_we       = 1'b0;
    br_en       = 1'b0;
    pc_en       = 1'b0;
    case (state)
      FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          ir_en      = 1'b1;
          next_state = SRC1;
        end
      end
      SRC1: begin
        if (is_halt) begin
          next_state = HALTED;
        end else begin
          bus_sel    = BUS_RS1;
          a_en       = 1'b1;
          next_state = SRC2;
        end
      end
      SRC2: begin
        bus_sel    = is_addi ? BUS_IMM : BUS_RS2;
        b_en       = 1'b1;
        next_state = EXEC;
      end
      EXEC: begin
        br_en      = 1'b1;
        next_state = PCUPD;
        unique case (1'b1)
          is_alu, is_addi: begin
            bus_sel = BUS_ALU;
            rf_we   = 1'b1;
          end
          is_beq:  bus_sel = BUS_ALU;
          default: bus_sel = BUS_NONE;
        endcase
      end
      PCUPD: begin
        bus_sel    = BUS_PC;
        pc_en      = 1'b1;
        next_state = FETCH;
      end
      HALTED:  next_state = HALTED;
      default: next_state = FETCH;
    endcase
  end

  always_comb begin
    bus = '0;
    case (bus_sel)
      BUS_RS1: bus = BUS_W'(rf[rs1]);
      BUS_RS2: bus = BUS_W'(rf[rs2]);
      BUS_IMM: bus = BUS_W'(rs2);
      BUS_ALU: bus = BUS_W'(alu_res);
      BUS_PC:  bus = BUS_W'(pc_next);
      default: bus = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc_q        <= '0;
      ir          <= '0;
      a_q         <= '0;
      b_q         <= '0;
      take_branch <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
        rf[i] <= '0;
    end else begin
      state <= next_state;
      if (ir_en) ir <= instr;
      if (a_en)  a_q <= bus[DATA_W-1:0];
      if (b_en)  b_q <= bus[DATA_W-1:0];
      if (rf_we) rf[rd] <= bus[DATA_W-1:0];
      if (br_en) take_branch <= is_beq & alu_zero;
      if (pc_en) pc_q <= bus[PC_W-1:0];
    end
  end

  assign pc      = pc_q;
  assign halted  = (state == HALTED);
  assign dbg_out = dbg_pc_sel ? DATA_W'(pc_q) : rf[dbg_sel];

endmodule

// File: tb/tb_common_bus_core.sv
// Bench for common_bus_core: directed table, corner sequences and
// random instructions against an instruction-level reference model.
`timescale 1ns/1ps
module tb_common_bus_core;

  localparam int IW = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] instr = '0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [7:0]    pc;
  logic          halted;
  logic [2:0]    dbg_sel = '0;
  logic          dbg_pc_sel = 1'b0;
  logic [7:0]    dbg_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_rf [8];
  logic [7:0] m_pc;
  logic       m_halted;

  typedef struct {
    logic [IW-1:0] ins;
    int            r;
    logic [7:0]    val;
    logic [7:0]    epc;
  } vec_t;

  common_bus_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .halted      (halted),
    .dbg_sel     (dbg_sel),
    .dbg_pc_sel  (dbg_pc_sel),
    .dbg_out     (dbg_out)
  );

  always #20 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [IW-1:0] enc(int op, int rd, int rs1, int rs2);
    return {3'(rd), 3'(rs1), 3'(rs2), 4'(op)};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    m_pc = '0;
    m_halted = 1'b0;
  endtask

  // Instruction-level semantics: one call = one retired instruction.
  task automatic model_step(input logic [IW-1:0] ins);
    int op, rs2, rs1, rd, sh, off;
    logic [7:0] a, b;
    op  = int'(ins[3:0]);
    rs2 = int'(ins[6:4]);
    rs1 = int'(ins[9:7]);
    rd  = int'(ins[12:10]);
    a   = m_rf[rs1];
    b   = m_rf[rs2];
    sh  = int'(b) % 8;
    case (op)
      0: m_rf[rd] = a + b;
      1: m_rf[rd] = a - b;
      2: m_rf[rd] = a ^ b;
      3: m_rf[rd] = ~(a & b);
      4: m_rf[rd] = a << sh;
      5: m_rf[rd] = a >> sh;
      6: m_rf[rd] = 8'($signed(a) >>> sh);
      7: m_rf[rd] = ~(a | b);
      8: m_rf[rd] = a + 8'(rs2);
      15: m_halted = 1'b1;
      default: ;
    endcase
    if (op != 15) begin
      if (op == 9 && a == b) begin
        off = (rd >= 4) ? rd - 8 : rd;
        m_pc = 8'(int'(m_pc) + off * 4);
      end else begin
        m_pc = m_pc + 8'd4;
      end
    end
  endtask

  task automatic check_state(string tag);
    chk({tag, " pc"}, 32'(pc), 32'(m_pc));
    chk({tag, " halted"}, 32'(halted), 32'(m_halted));
    chk({tag, " ready"}, 32'(instr_ready), 32'(!m_halted));
    dbg_pc_sel = 1'b1;
    #1;
    chk({tag, " dbg pc"}, 32'(dbg_out), 32'(m_pc));
    dbg_pc_sel = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1;
      chk($sformatf("%s r%0d", tag, i), 32'(dbg_out), 32'(m_rf[i]));
    end
  endtask

  task automatic issue(input logic [IW-1:0] ins, output int lat);
    int n;
    @(negedge clk);
    instr = ins;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      chk("handshake timeout", 32'(instr_ready), 32'd1);
      instr_valid = 1'b0;
      lat = -1;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instr = IW'($urandom);
    n = 1;
    while (!instr_ready && !halted && n < 30) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    model_step(ins);
  endtask

  task automatic run(input logic [IW-1:0] ins, string tag);
    int lat;
    issue(ins, lat);
    chk({tag, " latency"}, 32'(lat), (ins[3:0] == 4'd15) ? 32'd2 : 32'd5);
    check_state(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  vec_t tbl [12];

  initial begin
    int lat;
    logic [7:0] pc_hold;

    tbl[0]  = '{enc(8, 1, 0, 5), 1, 8'd5,   8'd4};
    tbl[1]  = '{enc(0, 2, 1, 1), 2, 8'd10,  8'd8};
    tbl[2]  = '{enc(1, 3, 0, 1), 3, 8'hFB,  8'd12};
    tbl[3]  = '{enc(6, 4, 3, 1), 4, 8'hFF,  8'd16};
    tbl[4]  = '{enc(9, 7, 1, 1), 1, 8'd5,   8'd12};
    tbl[5]  = '{enc(9, 7, 1, 2), 2, 8'd10,  8'd16};
    tbl[6]  = '{enc(2, 5, 1, 2), 5, 8'h0F,  8'd20};
    tbl[7]  = '{enc(3, 6, 1, 2), 6, 8'hFF,  8'd24};
    tbl[8]  = '{enc(4, 7, 1, 1), 7, 8'hA0,  8'd28};
    tbl[9]  = '{enc(5, 7, 7, 1), 7, 8'h05,  8'd32};
    tbl[10] = '{enc(7, 6, 1, 2), 6, 8'hF0,  8'd36};
    tbl[11] = '{enc(10, 6, 1, 2), 6, 8'hF0, 8'd40};

    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_state("reset");

    for (int i = 0; i < 12; i++) begin
      run(tbl[i].ins, $sformatf("tbl%0d", i));
      dbg_sel = 3'(tbl[i].r);
      #1;
      chk($sformatf("tbl%0d value", i), 32'(dbg_out), 32'(tbl[i].val));
      chk($sformatf("tbl%0d pc", i), 32'(pc), 32'(tbl[i].epc));
    end

    pc_hold = pc;
    repeat (7) begin
      @(negedge clk);
      chk("idle ready", 32'(instr_ready), 32'd1);
      chk("idle pc", 32'(pc), 32'(pc_hold));
    end
    check_state("idle");
    run(enc(12, 0, 0, 0), "after idle");

    run(enc(15, 0, 0, 0), "halt");
    pc_hold = pc;
    instr = enc(8, 1, 0, 3);
    instr_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("halted ready", 32'(instr_ready), 32'd0);
      chk("halted flag", 32'(halted), 32'd1);
      chk("halted pc", 32'(pc), 32'(pc_hold));
    end
    instr_valid = 1'b0;
    do_reset();
    check_state("halt reset");

    for (int i = 0; i < 8; i++)
      run(enc(8, i, i, $urandom_range(1, 7)), "seed");
    for (int k = 0; k < 150; k++)
      run(enc($urandom_range(0, 14), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 7)), "rand");

    do_reset();
    for (int i = 0; i < 63; i++)
      issue(enc(11, 1, 2, 3), lat);
    chk("pre-wrap pc", 32'(pc), 32'd252);
    run(enc(13, 1, 2, 3), "wrap");
    chk("wrap pc", 32'(pc), 32'd0);

    do_reset();
    run(enc(8, 5, 0, 3), "pre-abort");
    @(negedge clk);
    instr = enc(8, 5, 0, 7);
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    dbg_sel = 3'd5;
    #1;
    chk("abort r5", 32'(dbg_out), 32'd0);
    chk("abort pc", 32'(pc), 32'd0);
    check_state("abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
